// File: rtl/bilinear_simd_pkg.sv
// Shared definitions for the bilinear SIMD engine.
//   FRAC   : fractional weight bits (Q0.8 weights)
//   ONE_FP : fixed-point 1.0 for an 8-bit fraction
//   ROW_W  : width of a row interpolation (max 255*256 = 65280)
//   ACC_W  : width of the column accumulation (max 65280*256)
//   PIX_W  : pixel width
//   bsimd_state_t : engine FSM state encoding
package bilinear_simd_pkg;

  localparam int FRAC   = 8;
  localparam int ONE_FP = 256;
  localparam int ROW_W  = 16;
  localparam int ACC_W  = 24;
  localparam int PIX_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HORIZ = 2'd1,
    S_VERT  = 2'd2,
    S_DONE  = 2'd3
  } bsimd_state_t;

endpackage

// File: rtl/bilinear_simd_engine_lerp.sv
// bilinear_lerp8: combinational 1-D linear interpolation
//   o_y = i_a*(2^FRAC - i_w) + i_b*i_w
// Ports:
//   i_a, i_b : endpoint samples, IN_W bits unsigned
//   i_w      : weight toward i_b, Q0.FRAC
//   o_y      : unnormalised result, OUT_W bits (OUT_W = IN_W + FRAC
//              holds the exact result, since the weights sum to 2^FRAC)
module bilinear_lerp8
  import bilinear_simd_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int FRAC  = 8
) (
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  input  logic [FRAC-1:0]  i_w,
  output logic [OUT_W-1:0] o_y
);

  localparam int ONE = 1 << FRAC;

  // Complementary weight spans 1..2^FRAC, one bit wider than i_w.
  logic [OUT_W-1:0] w_wa;
  logic [OUT_W-1:0] w_wb;

  assign w_wa = OUT_W'(ONE - int'(i_w));
  assign w_wb = OUT_W'(i_w);

  // The exact sum never exceeds (2^IN_W - 1) * 2^FRAC, so OUT_W-bit
  // modular arithmetic gives the true value.
  assign o_y = OUT_W'(i_a) * w_wa + OUT_W'(i_b) * w_wb;

endmodule

// File: rtl/bilinear_simd_engine.sv
// bilinear_simd_engine: N-lane bilinear interpolation, responder side of
// the scaler start/done batch handshake.
//
// Handshake: start is sampled only in S_IDLE; on the accepting edge all
// lane inputs are captured. done pulses for one cycle when pixel_out_vec
// carries the new batch (two edges after acceptance). busy is high in
// every state except S_IDLE. A held start is re-accepted every 4 cycles.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : batch request
//   I00/I10/I01/I11_vec : per-lane neighbour pixels
//   alpha_vec, beta_vec : per-lane horizontal / vertical Q0.8 weights
//   busy, done          : status / completion pulse
//   pixel_out_vec       : per-lane result, held until the next batch
//   o_dbg_state         : current FSM state for observation
//
// Build option: BILINEAR_ROUND_EN selects round-half-up on the final
// pixel; undefined (default) truncates.
module bilinear_simd_engine #(
  parameter int N    = 4,
  parameter int FRAC = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [7:0]                     I00_vec       [N],
  input  logic [7:0]                     I10_vec       [N],
  input  logic [7:0]                     I01_vec       [N],
  input  logic [7:0]                     I11_vec       [N],
  input  logic [FRAC-1:0]                alpha_vec     [N],
  input  logic [FRAC-1:0]                beta_vec      [N],
  output logic                           busy,
  output logic                           done,
  output logic [7:0]                     pixel_out_vec [N],
  output bilinear_simd_pkg::bsimd_state_t o_dbg_state
);

  import bilinear_simd_pkg::*;

  bsimd_state_t     r_state;
  logic             r_busy;
  logic             r_done;

  logic [7:0]       r_i00   [N];
  logic [7:0]       r_i10   [N];
  logic [7:0]       r_i01   [N];
  logic [7:0]       r_i11   [N];
  logic [FRAC-1:0]  r_alpha [N];
  logic [FRAC-1:0]  r_beta  [N];
  logic [ROW_W-1:0] r_top   [N];
  logic [ROW_W-1:0] r_bot   [N];
  logic [7:0]       r_pix   [N];

  logic [ROW_W-1:0] w_top   [N];
  logic [ROW_W-1:0] w_bot   [N];
  logic [ACC_W-1:0] w_acc   [N];
  logic [7:0]       w_pix   [N];

  for (genvar g = 0; g < N; g++) begin : g_lane
    bilinear_lerp8 #(.IN_W(8), .OUT_W(ROW_W), .FRAC(FRAC)) u_lerp_top (
      .i_a (r_i00[g]),
      .i_b (r_i10[g]),
      .i_w (r_alpha[g]),
      .o_y (w_top[g])
    );

    bilinear_lerp8 #(.IN_W(8), .OUT_W(ROW_W), .FRAC(FRAC)) u_lerp_bot (
      .i_a (r_i01[g]),
      .i_b (r_i11[g]),
      .i_w (r_alpha[g]),
      .o_y (w_bot[g])
    );

    bilinear_lerp8 #(.IN_W(ROW_W), .OUT_W(ACC_W), .FRAC(FRAC)) u_lerp_col (
      .i_a (r_top[g]),
      .i_b (r_bot[g]),
      .i_w (r_beta[g]),
      .o_y (w_acc[g])
    );

    // The accumulator carries 2*FRAC fraction bits; the pixel is the top
    // byte. Adding the half-LSB cannot carry out of 24 bits because the
    // accumulator peaks at 255*65536.
`ifdef BILINEAR_ROUND_EN
    assign w_pix[g] = 8'((w_acc[g] + ACC_W'(1 << (2*FRAC - 1))) >> (2*FRAC));
`else
    assign w_pix[g] = 8'(w_acc[g] >> (2*FRAC));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_i00[k]   <= '0;
        r_i10[k]   <= '0;
        r_i01[k]   <= '0;
        r_i11[k]   <= '0;
        r_alpha[k] <= '0;
        r_beta[k]  <= '0;
        r_top[k]   <= '0;
        r_bot[k]   <= '0;
        r_pix[k]   <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < N; k++) begin
              r_i00[k]   <= I00_vec[k];
              r_i10[k]   <= I10_vec[k];
              r_i01[k]   <= I01_vec[k];
              r_i11[k]   <= I11_vec[k];
              r_alpha[k] <= alpha_vec[k];
              r_beta[k]  <= beta_vec[k];
            end
            r_busy  <= 1'b1;
            r_state <= S_HORIZ;
          end
        end
        S_HORIZ: begin
          for (int k = 0; k < N; k++) begin
            r_top[k] <= w_top[k];
            r_bot[k] <= w_bot[k];
          end
          r_state <= S_VERT;
        end
        S_VERT: begin
          for (int k = 0; k < N; k++) begin
            r_pix[k] <= w_pix[k];
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // busy drops together with the return to S_IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pixel_out_vec = r_pix;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_bilinear_simd_engine.sv
// Self-checking bench for bilinear_simd_engine. Inputs are driven and
// outputs sampled on the falling clock edge. Expected pixels come from a
// plain-integer bilinear model and are queued in exp_q until done.
module tb_bilinear_simd_engine;
  import bilinear_simd_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [7:0]       i00 [N];
  logic [7:0]       i10 [N];
  logic [7:0]       i01 [N];
  logic [7:0]       i11 [N];
  logic [7:0]       al  [N];
  logic [7:0]       be  [N];
  logic             busy;
  logic             done;
  logic [7:0]       pix [N];
  bsimd_state_t     dbg_state;

  logic [7:0]       exp_q [$];
  int               total = 0;
  int               bad   = 0;

  bilinear_simd_engine #(.N(N), .FRAC(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .I00_vec       (i00),
    .I10_vec       (i10),
    .I01_vec       (i01),
    .I11_vec       (i11),
    .alpha_vec     (al),
    .beta_vec      (be),
    .busy          (busy),
    .done          (done),
    .pixel_out_vec (pix),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic int ref_pix(int a00, int a10, int a01, int a11, int a, int b);
    int top;
    int bot;
    int acc;
    top = a00 * (256 - a) + a10 * a;
    bot = a01 * (256 - a) + a11 * a;
    acc = top * (256 - b) + bot * b;
`ifdef BILINEAR_ROUND_EN
    acc = acc + 32768;
`endif
    return acc / 65536;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_all(input int v00, input int v10, input int v01,
                         input int v11, input int a, input int b);
    for (int k = 0; k < N; k++) begin
      i00[k] = 8'(v00); i10[k] = 8'(v10); i01[k] = 8'(v01);
      i11[k] = 8'(v11); al[k]  = 8'(a);   be[k]  = 8'(b);
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < N; k++) begin
      i00[k] = 8'($urandom_range(0, 255));
      i10[k] = 8'($urandom_range(0, 255));
      i01[k] = 8'($urandom_range(0, 255));
      i11[k] = 8'($urandom_range(0, 255));
      al[k]  = 8'($urandom_range(0, 255));
      be[k]  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < N; k++)
      exp_q.push_back(8'(ref_pix(i00[k], i10[k], i01[k], i11[k], al[k], be[k])));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs(input string name);
    logic [7:0] e;
    for (int k = 0; k < N; k++) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s lane%0d: got=%0d but expected queue is empty", name, k, pix[k]);
      end else begin
        e = exp_q.pop_front();
        if (pix[k] !== e) begin
          bad++;
          $display("FAIL %s lane%0d: got=%0d exp=%0d", name, k, pix[k], e);
        end
      end
    end
  endtask

  // One batch with a single-cycle start pulse; checks latency, busy, the
  // done pulse width and the lane results.
  task automatic run_batch(input string name);
    int lat;
    push_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_accept: got=%b exp=1", name, busy);
    end
    while (done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != 3) begin
      bad++; $display("FAIL %s done_latency: got=%0d exp=3", name, lat);
    end
    check_outputs(name);
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s done_fall: done=%b busy=%b exp 0/0", name, done, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_all(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== S_IDLE) begin
      bad++; $display("FAIL reset_status: busy=%b done=%b state=%0d exp 0/0/0", busy, done, dbg_state);
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (pix[k] !== 8'd0) begin
        bad++; $display("FAIL reset_pix lane%0d: got=%0d exp=0", k, pix[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    set_all(10, 20, 30, 40, 0, 0);
    run_batch("identity");
    total++;
    if (pix[N-1] !== 8'd10) begin
      bad++; $display("FAIL identity_const: got=%0d exp=10", pix[N-1]);
    end
  endtask

  task automatic test_half_horiz();
    logic [7:0] want;
`ifdef BILINEAR_ROUND_EN
    want = 8'd128;
`else
    want = 8'd127;
`endif
    set_all(0, 255, 0, 255, 128, 0);
    run_batch("half_horiz");
    total++;
    if (pix[0] !== want) begin
      bad++; $display("FAIL half_horiz_const: got=%0d exp=%0d", pix[0], want);
    end
  endtask

  task automatic test_centre();
    set_all(0, 100, 100, 200, 128, 128);
    run_batch("centre");
    total++;
    if (pix[1] !== 8'd100) begin
      bad++; $display("FAIL centre_const: got=%0d exp=100", pix[1]);
    end
  endtask

  task automatic test_lanes();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) begin
        i00[k] = 8'(50 * k); i10[k] = 8'(50 * k);
        i01[k] = 8'(50 * k); i11[k] = 8'(50 * k);
        al[k]  = 8'($urandom_range(0, 255));
        be[k]  = 8'($urandom_range(0, 255));
      end
      run_batch("lanes");
      for (int k = 0; k < N; k++) begin
        total++;
        if (pix[k] !== 8'(50 * k)) begin
          bad++; $display("FAIL lanes_const lane%0d: got=%0d exp=%0d", k, pix[k], 50 * k);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      set_random();
      run_batch("random");
    end
  endtask

  task automatic test_busy();
    logic [7:0] first [N];
    set_random();
    for (int k = 0; k < N; k++)
      first[k] = 8'(ref_pix(i00[k], i10[k], i01[k], i11[k], al[k], be[k]));
    push_expected();
    start = 1'b1;
    @(negedge clk);              // after acceptance: S_HORIZ
    set_random();                // new data and start re-pulsed
    total++;
    if (busy !== 1'b1 || dbg_state !== S_HORIZ) begin
      bad++; $display("FAIL busy_horiz: busy=%b state=%0d exp 1/%0d", busy, dbg_state, S_HORIZ);
    end
    @(negedge clk);              // S_VERT
    set_random();
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL busy_vert: busy=%b done=%b exp 1/0", busy, done);
    end
    @(negedge clk);              // S_DONE
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL busy_done: busy=%b done=%b exp 1/1", busy, done);
    end
    check_outputs("busy_first_batch");
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      total++;
      if (pix[k] !== first[k] || done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL busy_hold lane%0d: pix=%0d exp=%0d done=%b busy=%b", k, pix[k], first[k], done, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    set_random();
    start = 1'b1;
    @(negedge clk);              // S_HORIZ
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== S_IDLE) begin
      bad++; $display("FAIL reset_mid_status: done=%b busy=%b state=%0d exp 0/0/0", done, busy, dbg_state);
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (pix[k] !== 8'd0) begin
        bad++; $display("FAIL reset_mid_pix lane%0d: got=%0d exp=0", k, pix[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL reset_mid_no_done: done_cycles=%0d exp=0", seen);
    end
    set_random();
    run_batch("after_reset");
  endtask

  task automatic test_back_to_back();
    set_random();
    push_expected();
    start = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);            // just after the accepting edge
      if (b < 2) begin
        set_random();
        push_expected();
      end else begin
        start = 1'b0;
      end
      repeat (2) @(negedge clk);
      total++;
      if (done !== 1'b1) begin
        bad++; $display("FAIL b2b_done batch%0d: got=%b exp=1", b, done);
      end
      check_outputs("b2b");
      @(negedge clk);
      total++;
      if (done !== 1'b0 || dbg_state !== S_IDLE) begin
        bad++; $display("FAIL b2b_idle batch%0d: done=%b state=%0d exp 0/0", b, done, dbg_state);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_identity();
    test_half_horiz();
    test_centre();
    test_lanes();
    test_random();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover_expected: got=%0d entries exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
